mem_window: RTL

- Parametrised successor to the single-port offset memory.
- Maps a DEPTH-entry window of a wider address space, starting at OFFSET, onto storage.
- Adds NRD independent read ports, byte-strobed writes, selectable read-during-write policy, and out-of-window access detection with sticky and counted error reporting.
- Used as the generic emulated memory model inside test and target designs.

---
 rtl/mem_window.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_window.sv
// mem_window: windowed emulated memory.
//   Maps external addresses OFFSET .. OFFSET+DEPTH-1 onto a DEPTH-entry store.
//   NRD independent read ports (registered or combinational), one byte-strobed
//   write port, selectable read-during-write result, out-of-window detection
//   with a sticky flag and a saturating error counter.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ren/raddr         per-port read enable / address (port i at [i*ADDR_WIDTH +: ADDR_WIDTH])
//   rdata/rvalid/rerr per-port read data (port i at [i*WIDTH +: WIDTH]), valid, out-of-window flag
//   wen/waddr/wdata/wstrb  write enable, address, data, byte enables
//   werr              one-cycle pulse after an out-of-window write
//   err_clear         clear for err_sticky / err_count (same-cycle events still counted)
//   err_sticky        any out-of-window access seen
//   err_count         saturating number of out-of-window accesses
module mem_window #(
  parameter int WIDTH        = 80,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int OFFSET       = 32,
  parameter int NRD          = 2,
  parameter int SYNCREAD     = 1,
  parameter int RDW_NEW      = 0,
  parameter int ERRCNT_WIDTH = 8,
  localparam int BE          = (WIDTH + 7) / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NRD-1:0]            ren,
  input  logic [NRD*ADDR_WIDTH-1:0] raddr,
  output logic [NRD*WIDTH-1:0]      rdata,
  output logic [NRD-1:0]            rvalid,
  output logic [NRD-1:0]            rerr,
  input  logic                      wen,
  input  logic [ADDR_WIDTH-1:0]     waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [BE-1:0]             wstrb,
  output logic                      werr,
  input  logic                      err_clear,
  output logic                      err_sticky,
  output logic [ERRCNT_WIDTH-1:0]   err_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so OFFSET+DEPTH == 2^ADDR_WIDTH is representable (no wrap).
  localparam int EW    = ADDR_WIDTH + 1;
  localparam logic [EW-1:0] LO = EW'(OFFSET);
  localparam logic [EW-1:0] HI = EW'(OFFSET + DEPTH);
  localparam int EV_W  = $clog2(NRD + 2);
  localparam int SUM_W = ((ERRCNT_WIDTH > EV_W) ? ERRCNT_WIDTH : EV_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({ERRCNT_WIDTH{1'b1}});

  function automatic logic in_win(input logic [ADDR_WIDTH-1:0] a);
    logic [EW-1:0] e;
    e = {1'b0, a};
    return (e >= LO) && (e < HI);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [EW-1:0] d;
    d = {1'b0, a} - LO;
    return d[IDX_W-1:0];
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------- write port ----------------
  logic [WIDTH-1:0] wmask;
  logic             w_in;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_merged;

  // Expand byte strobes to a bit mask; the top strobe naturally covers only
  // the leftover bits when WIDTH is not a multiple of 8.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    assign wmask[gi] = wstrb[gi/8];
  end

  assign w_in     = in_win(waddr);
  assign w_idx    = to_idx(waddr);
  assign w_merged = (mem[w_idx] & ~wmask) | (wdata & wmask);

  always_ff @(posedge clk) begin
    if (wen && w_in) begin
      mem[w_idx] <= w_merged;
    end
  end

  // ---------------- read ports ----------------
  logic [NRD-1:0] rd_err;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  r_in;
    logic [IDX_W-1:0]      r_idx;

    assign ra         = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign r_in       = in_win(ra);
    assign r_idx      = to_idx(ra);
    assign rd_err[gi] = ren[gi] && !r_in;

    if (SYNCREAD != 0) begin : g_sync
      logic [WIDTH-1:0] rdata_reg;
      logic             rvalid_reg;
      logic             rerr_reg;
      logic             hit;

      // Same in-window index written this edge: only matters for RDW_NEW.
      assign hit = r_in && wen && w_in && (r_idx == w_idx);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
          rerr_reg   <= 1'b0;
        end else begin
          rvalid_reg <= ren[gi];
          rerr_reg   <= ren[gi] && !r_in;
          if (ren[gi]) begin
            if (!r_in)
              rdata_reg <= '0;
            else if ((RDW_NEW != 0) && hit)
              rdata_reg <= w_merged;
            else
              rdata_reg <= mem[r_idx];
          end
        end
      end

      assign rdata[gi*WIDTH +: WIDTH] = rdata_reg;
      assign rvalid[gi]               = rvalid_reg;
      assign rerr[gi]                 = rerr_reg;
    end else begin : g_async
      assign rdata[gi*WIDTH +: WIDTH] = (ren[gi] && r_in) ? mem[r_idx] : '0;
      assign rvalid[gi]               = ren[gi];
      assign rerr[gi]                 = ren[gi] && !r_in;
    end
  end

  // ---------------- error accounting ----------------
  logic             werr_now;
  logic [EV_W-1:0]  events;
  logic [SUM_W-1:0] sum_next;
  logic             werr_reg;
  logic             err_sticky_reg;
  logic [ERRCNT_WIDTH-1:0] err_count_reg;

  assign werr_now = wen && !w_in;

  always_comb begin
    events = EV_W'(werr_now);
    for (int i = 0; i < NRD; i++) begin
      events = events + EV_W'(rd_err[i]);
    end
  end

  // Clear drops the old count first; this cycle's events are still added.
  assign sum_next = (err_clear ? '0 : SUM_W'(err_count_reg)) + SUM_W'(events);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      werr_reg       <= 1'b0;
      err_sticky_reg <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      werr_reg       <= werr_now;
      err_sticky_reg <= (err_sticky_reg && !err_clear) || (events != '0);
      err_count_reg  <= (sum_next > CNT_MAX) ? CNT_MAX[ERRCNT_WIDTH-1:0]
                                             : sum_next[ERRCNT_WIDTH-1:0];
    end
  end

  assign werr       = werr_reg;
  assign err_sticky = err_sticky_reg;
  assign err_count  = err_count_reg;

endmodule
